ssd_scan_ctrl: RTL and testbench



---
 rtl/ssd_scan_ctrl_if.sv | 25 ++
 rtl/ssd_scan_ctrl.sv | 116 +++++++++++
 tb/tb_ssd_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_ctrl_if.sv
// Display bus between score logic (master) and the seven-segment scan controller (slave).
// Carries the digit data and controls in, and the active-low pin drives out.
interface ssd_scan_ctrl_if #(
   parameter int NUM_DIGITS = 8,
   parameter int DIM_BITS   = 4
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    lz_suppress;
   logic [DIM_BITS-1:0]     brightness;
   logic [NUM_DIGITS-1:0]   an_n;
   logic [7:0]              seg_n;
   logic                    frame_done;

   modport master (
      output digits_in, dp_in, blank_in, lz_suppress, brightness,
      input  an_n, seg_n, frame_done
   );

   modport slave (
      input  digits_in, dp_in, blank_in, lz_suppress, brightness,
      output an_n, seg_n, frame_done
   );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with frame-coherent snapshot,
// per-digit blanking, leading-zero suppression and PWM brightness.
module ssd_scan_ctrl #(
   parameter int NUM_DIGITS    = 8,
   parameter int SCAN_DIV_BITS = 17,
   parameter int DIM_BITS      = 4
) (
   input  logic           ClkPort,
   input  logic           Reset,
   ssd_scan_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic [SCAN_DIV_BITS-1:0] presc;
   logic [IDX_W-1:0]         idx;
   logic                     load_pending;
   logic [4*NUM_DIGITS-1:0]  dig_sh;
   logic [NUM_DIGITS-1:0]    dp_sh;
   logic [NUM_DIGITS-1:0]    blank_sh;
   logic [NUM_DIGITS-1:0]    sup_sh;
   logic [NUM_DIGITS-1:0]    an_p1;
   logic [7:0]               seg_p1;
   logic                     frame_p1;

   logic                tick;
   logic                last_digit;
   logic                wrap;
   logic                load;
   logic                pwm_on;
   logic                show;
   logic [3:0]          cur_nib;
   logic [DIM_BITS-1:0] pwm_level;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   // Walk down from the top digit; a nonzero nibble or a lit dp ends the zero run.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(
      input logic [4*NUM_DIGITS-1:0] dig,
      input logic [NUM_DIGITS-1:0]   dp,
      input logic                    en
   );
      logic alive;
      lz_mask = '0;
      alive   = en;
      for (int k = NUM_DIGITS-1; k >= 1; k--) begin
         if (alive && (dig[4*k +: 4] == 4'h0) && !dp[k]) lz_mask[k] = 1'b1;
         else                                            alive      = 1'b0;
      end
   endfunction

   assign tick       = &presc;
   assign last_digit = (idx == IDX_W'(NUM_DIGITS-1));
   assign wrap       = tick && last_digit;
   assign load       = wrap || load_pending;
   assign pwm_level  = presc[SCAN_DIV_BITS-1 -: DIM_BITS];
   assign pwm_on     = (&bus.brightness) || (pwm_level < bus.brightness);
   assign cur_nib    = dig_sh[{idx, 2'b00} +: 4];
   assign show       = pwm_on && !blank_sh[idx] && !sup_sh[idx];

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         presc        <= '0;
         idx          <= '0;
         load_pending <= 1'b1;
         dig_sh       <= '0;
         dp_sh        <= '0;
         blank_sh     <= '0;
         sup_sh       <= '0;
         an_p1        <= '1;
         seg_p1       <= 8'hFF;
         frame_p1     <= 1'b0;
      end else begin
         presc <= presc + 1'b1;
         if (tick) idx <= last_digit ? '0 : idx + 1'b1;
         if (load) begin
            dig_sh       <= bus.digits_in;
            dp_sh        <= bus.dp_in;
            blank_sh     <= bus.blank_in;
            sup_sh       <= lz_mask(bus.digits_in, bus.dp_in, bus.lz_suppress);
            load_pending <= 1'b0;
         end
         // output register stage: one cycle behind index/prescaler
         frame_p1 <= wrap;
         if (show) begin
            an_p1  <= ~(NUM_DIGITS'(1) << idx);
            seg_p1 <= {hex7(cur_nib), ~dp_sh[idx]};
         end else begin
            an_p1  <= '1;
            seg_p1 <= 8'hFF;
         end
      end
   end

   assign bus.an_n       = an_p1;
   assign bus.seg_n      = seg_p1;
   assign bus.frame_done = frame_p1;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a cycle model pushes expected pin values
// every clock and each scenario task pops and compares them, plus directed checks.
module tb_ssd_scan_ctrl;
   localparam int ND  = 4;
   localparam int SDB = 2;
   localparam int DB  = 2;

   localparam logic [6:0] HEX [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] seg;
      logic       fd;
   } exp_t;

   logic ClkPort;
   logic Reset;
   int   total;
   int   bad;
   exp_t sb[$];

   ssd_scan_ctrl_if #(.NUM_DIGITS(ND), .DIM_BITS(DB)) bus ();

   ssd_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV_BITS(SDB), .DIM_BITS(DB)) dut (
      .ClkPort (ClkPort),
      .Reset   (Reset),
      .bus     (bus)
   );

   wire [12:0] obs = {bus.an_n, bus.seg_n, bus.frame_done};

   initial begin
      ClkPort = 1'b0;
      forever #5 ClkPort = ~ClkPort;
   end

   // reference model state
   int         m_presc;
   int         m_idx;
   bit         m_pend;
   logic [15:0] m_dig;
   logic [3:0] m_dp, m_blank, m_sup;

   always @(posedge ClkPort) begin : model
      exp_t e;
      int   lvl;
      logic [3:0] nib;
      if (Reset) begin
         m_presc = 0; m_idx = 0; m_pend = 1'b1;
         m_dig = '0; m_dp = '0; m_blank = '0; m_sup = '0;
         e = '{an: 4'hF, seg: 8'hFF, fd: 1'b0};
      end else begin
         lvl = m_presc >> (SDB - DB);
         nib = m_dig[m_idx*4 +: 4];
         if (((bus.brightness == 2'd3) || (lvl < int'(bus.brightness)))
             && !m_blank[m_idx] && !m_sup[m_idx]) begin
            e.an  = 4'hF ^ (4'b0001 << m_idx);
            e.seg = {HEX[nib], ~m_dp[m_idx]};
         end else begin
            e.an  = 4'hF;
            e.seg = 8'hFF;
         end
         e.fd = (m_presc == 3) && (m_idx == 3);
         if (m_pend || e.fd) begin
            m_dig = bus.digits_in; m_dp = bus.dp_in; m_blank = bus.blank_in;
            for (int k = 0; k < ND; k++)
               m_sup[k] = bus.lz_suppress && (k != 0) &&
                          ((bus.digits_in >> (4*k)) == 16'h0) && ((bus.dp_in >> k) == 4'h0);
         end
         m_pend  = 1'b0;
         m_presc = (m_presc + 1) % 4;
         if (m_presc == 0) m_idx = (m_idx + 1) % ND;
      end
      sb.push_back(e);
   end

   task automatic test_reset();
      exp_t e;
      Reset = 1'b1;
      bus.digits_in = 16'h1234; bus.dp_in = '0; bus.blank_in = '0;
      bus.lz_suppress = 1'b0; bus.brightness = 2'd3;
      repeat (3) begin
         @(posedge ClkPort); #1;
         e = sb.pop_front();
         total++;
         if (obs !== e || obs !== {4'hF, 8'hFF, 1'b0}) begin
            bad++; $display("FAIL reset_hold got=%h want=%h", obs, {4'hF, 8'hFF, 1'b0});
         end
      end
      @(negedge ClkPort); Reset = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge ClkPort); #1;
         total++;
         if (sb.size() == 0) begin bad++; $display("FAIL reset_sb empty"); end
         else begin
            e = sb.pop_front();
            if (obs !== e) begin bad++; $display("FAIL reset_seq c=%0d got=%h want=%h", c, obs, e); end
         end
         if (c == 2 || c == 5 || c == 9 || c == 13 || c == 16) begin
            total++;
            if ((c == 2  && {bus.an_n, bus.seg_n} !== {4'b1110, 8'b1001100_1}) ||
                (c == 5  && {bus.an_n, bus.seg_n} !== {4'b1101, 8'b0000110_1}) ||
                (c == 9  && {bus.an_n, bus.seg_n} !== {4'b1011, 8'b0010010_1}) ||
                (c == 13 && {bus.an_n, bus.seg_n} !== {4'b0111, 8'b1001111_1}) ||
                (c == 16 && bus.frame_done !== 1'b1)) begin
               bad++; $display("FAIL reset_digit c=%0d got an=%b seg=%b fd=%b", c, bus.an_n, bus.seg_n, bus.frame_done);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      exp_t e;
      bit   seen_fd, early, d_after;
      seen_fd = 0; early = 0; d_after = 0;
      @(negedge ClkPort); bus.digits_in = 16'hABCD;
      for (int c = 1; c <= 32; c++) begin
         @(posedge ClkPort); #1;
         total++;
         if (sb.size() == 0) begin bad++; $display("FAIL snap_sb empty"); end
         else begin
            e = sb.pop_front();
            if (obs !== e) begin bad++; $display("FAIL snap_seq c=%0d got=%h want=%h", c, obs, e); end
         end
         if (!seen_fd && bus.an_n != 4'hF && bus.seg_n[7:1] inside {HEX[10], HEX[11], HEX[12], HEX[13]})
            early = 1;
         if (seen_fd && bus.an_n == 4'b1110 && bus.seg_n == {HEX[13], 1'b1}) d_after = 1;
         if (bus.frame_done) seen_fd = 1;
      end
      total++;
      if (early || !d_after) begin
         bad++; $display("FAIL snap_coherent early=%0d d_after_wrap=%0d want 0/1", early, d_after);
      end
   endtask

   task automatic test_leading_zero();
      exp_t       e;
      logic [3:0] lit;
      logic [3:0] want [3] = '{4'b0001, 4'b0111, 4'b0001};
      logic [15:0] digs [3] = '{16'h0005, 16'h0005, 16'h0000};
      logic [3:0] dps  [3] = '{4'b0000, 4'b0100, 4'b0000};
      for (int t = 0; t < 3; t++) begin
         @(negedge ClkPort);
         bus.lz_suppress = 1'b1; bus.digits_in = digs[t]; bus.dp_in = dps[t];
         lit = '0;
         for (int c = 1; c <= 32; c++) begin
            @(posedge ClkPort); #1;
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL lz_sb empty"); end
            else begin
               e = sb.pop_front();
               if (obs !== e) begin bad++; $display("FAIL lz_seq t=%0d c=%0d got=%h want=%h", t, c, obs, e); end
            end
            if (c > 16) lit |= ~bus.an_n;
            if (c > 16 && t == 2 && bus.an_n == 4'b1110) begin
               total++;
               if (bus.seg_n !== 8'b0000001_1) begin
                  bad++; $display("FAIL lz_zero_digit0 got=%b want=%b", bus.seg_n, 8'b0000001_1);
               end
            end
         end
         total++;
         if (lit !== want[t]) begin bad++; $display("FAIL lz_lit t=%0d got=%b want=%b", t, lit, want[t]); end
      end
   endtask

   task automatic test_blank_brightness();
      exp_t       e;
      logic [3:0] lit;
      int         on_cnt;
      logic [1:0] br [3] = '{2'd3, 2'd1, 2'd0};
      int         want_cnt [3] = '{12, 3, 0};
      @(negedge ClkPort);
      bus.lz_suppress = 1'b0; bus.dp_in = '0; bus.digits_in = 16'h1234; bus.blank_in = 4'b0010;
      for (int t = 0; t < 3; t++) begin
         if (t != 0) begin @(negedge ClkPort); end
         bus.brightness = br[t];
         lit = '0; on_cnt = 0;
         for (int c = 1; c <= 32; c++) begin
            @(posedge ClkPort); #1;
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL bb_sb empty"); end
            else begin
               e = sb.pop_front();
               if (obs !== e) begin bad++; $display("FAIL bb_seq t=%0d c=%0d got=%h want=%h", t, c, obs, e); end
            end
            if (c > 16) begin
               lit |= ~bus.an_n;
               if (bus.an_n != 4'hF) on_cnt++;
            end
         end
         total++;
         if (lit[1] !== 1'b0 || on_cnt != want_cnt[t]) begin
            bad++; $display("FAIL bb_level t=%0d lit=%b on=%0d want digit1 dark on=%0d", t, lit, on_cnt, want_cnt[t]);
         end
      end
   endtask

   task automatic test_tick_change();
      exp_t e;
      bit   found, after_fd, checked;
      found = 0; after_fd = 0; checked = 0;
      @(negedge ClkPort);
      bus.blank_in = '0; bus.brightness = 2'd3; bus.digits_in = 16'h1234;
      for (int c = 0; c < 40 && !found; c++) begin
         @(posedge ClkPort); #1;
         e = sb.pop_front();
         total++;
         if (obs !== e) begin bad++; $display("FAIL tick_pre got=%h want=%h", obs, e); end
         if (m_presc == 3 && m_idx == 3) found = 1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL tick_wait no wrap tick within budget"); end
      @(negedge ClkPort); bus.digits_in = 16'h5678;
      for (int c = 1; c <= 8; c++) begin
         @(posedge ClkPort); #1;
         e = sb.pop_front();
         total++;
         if (obs !== e) begin bad++; $display("FAIL tick_seq c=%0d got=%h want=%h", c, obs, e); end
         if (after_fd && !checked) begin
            checked = 1;
            total++;
            if ({bus.an_n, bus.seg_n} !== {4'b1110, 8'b0000000_1}) begin
               bad++; $display("FAIL tick_capture got an=%b seg=%b want 1110/00000001", bus.an_n, bus.seg_n);
            end
         end
         if (bus.frame_done) after_fd = 1;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   found;
      int   first_fd;
      found = 0; first_fd = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(posedge ClkPort); #1;
         e = sb.pop_front();
         total++;
         if (obs !== e) begin bad++; $display("FAIL mid_pre got=%h want=%h", obs, e); end
         if (m_idx == 2 && m_presc == 1) found = 1;
      end
      Reset = 1'b1;
      #1;
      total++;
      if (!found || bus.an_n !== 4'hF || bus.seg_n !== 8'hFF || bus.frame_done !== 1'b0) begin
         bad++; $display("FAIL mid_async found=%0d an=%b seg=%h fd=%b want F/FF/0", found, bus.an_n, bus.seg_n, bus.frame_done);
      end
      repeat (2) begin
         @(posedge ClkPort); #1;
         e = sb.pop_front();
         total++;
         if (obs !== e) begin bad++; $display("FAIL mid_hold got=%h want=%h", obs, e); end
      end
      @(negedge ClkPort); Reset = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         @(posedge ClkPort); #1;
         e = sb.pop_front();
         total++;
         if (obs !== e) begin bad++; $display("FAIL mid_seq c=%0d got=%h want=%h", c, obs, e); end
         if (bus.frame_done && first_fd == 0) first_fd = c;
      end
      total++;
      if (first_fd != 16) begin bad++; $display("FAIL mid_first_fd got=%0d want=16", first_fd); end
   endtask

   initial begin
      total = 0; bad = 0;
      test_reset();
      test_snapshot();
      test_leading_zero();
      test_blank_brightness();
      test_tick_change();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
